// File: rtl/text_console_renderer.sv
// text_console_renderer: character-cell text renderer for the VGA path.
// Three-stage pipeline (text fetch, font fetch, colour) producing one RGB333
// pixel per clock, three cycles after the matching pixelValid.
module text_console_renderer #(
  parameter int unsigned       CHAR_W       = 8,
  parameter int unsigned       CHAR_H       = 10,
  parameter int unsigned       COLS         = 80,
  parameter int unsigned       ROWS         = 48,
  parameter int unsigned       ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] TEXT_BASE    = ADDR_W'(16'h0000),
  parameter logic [ADDR_W-1:0] FONT_BASE    = ADDR_W'(16'h2000),
  parameter bit                ATTR_EN      = 1'b1,
  parameter logic [8:0]        FG_COLOR     = 9'h1FF,
  parameter logic [8:0]        BG_COLOR     = 9'h000,
  parameter int unsigned       BLINK_FRAMES = 30
) (
  input  logic              vgaClock,
  input  logic              reset,
  input  logic              frameStart,
  input  logic              lineEnd,
  input  logic              pixelValid,
  input  logic              cursorEn,
  input  logic [7:0]        cursorCol,
  input  logic [7:0]        cursorRow,
  output logic [ADDR_W-1:0] textAddr,
  input  logic [15:0]       textData,
  output logic [ADDR_W-1:0] fontAddr,
  input  logic [CHAR_W-1:0] fontData,
  output logic [8:0]        pixelData,
  output logic              pixelOutValid
);

  localparam int unsigned PX_W   = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  localparam int unsigned COL_W  = $clog2(COLS + 1);
  localparam int unsigned RIC_W  = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
  localparam int unsigned CROW_W = $clog2(ROWS + 1);
  localparam int unsigned BF_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PX_W-1:0]   PX_LAST  = PX_W'(CHAR_W - 1);
  localparam logic [PX_W-1:0]   PX_ONE   = PX_W'(1'b1);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(COLS);
  localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1'b1);
  localparam logic [RIC_W-1:0]  RIC_LAST = RIC_W'(CHAR_H - 1);
  localparam logic [RIC_W-1:0]  RIC_CUR  = RIC_W'(CHAR_H - 2);
  localparam logic [RIC_W-1:0]  RIC_ONE  = RIC_W'(1'b1);
  localparam logic [CROW_W-1:0] CROW_MAX = CROW_W'(ROWS);
  localparam logic [CROW_W-1:0] CROW_ONE = CROW_W'(1'b1);
  localparam logic [BF_W-1:0]   BF_LAST  = BF_W'(BLINK_FRAMES - 1);
  localparam logic [BF_W-1:0]   BF_ONE   = BF_W'(1'b1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] CHAR_H_A = ADDR_W'(CHAR_H);

  // One attribute channel: c selects the bright/dim pair, i the intensity.
  function automatic logic [2:0] chan_level(input logic c, input logic i);
    logic [2:0] lvl;
    if (c) begin
      lvl = i ? 3'b111 : 3'b101;
    end else begin
      lvl = i ? 3'b010 : 3'b000;
    end
    return lvl;
  endfunction

  // Attribute nibble {i,r,g,b} to RGB333.
  function automatic logic [8:0] attr_color(input logic [3:0] nib);
    return {chan_level(nib[2], nib[3]), chan_level(nib[1], nib[3]),
            chan_level(nib[0], nib[3])};
  endfunction

  // Raster position counters
  logic [PX_W-1:0]   px_q, px_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [RIC_W-1:0]  ric_q, ric_d;
  logic [CROW_W-1:0] crow_q, crow_d;
  logic [ADDR_W-1:0] rbase_q, rbase_d;
  // Blink state
  logic [BF_W-1:0]   fcnt_q, fcnt_d;
  logic              blink_q, blink_d;
  // Stage T -> T+1
  logic              v1_q, v1_d, blank1_q, blank1_d, hit1_q, hit1_d;
  logic [PX_W-1:0]   px1_q, px1_d;
  logic [RIC_W-1:0]  ric1_q, ric1_d;
  // Stage T+1 -> T+2
  logic              v2_q, v2_d, blank2_q, blank2_d, hit2_q, hit2_d;
  logic [PX_W-1:0]   px2_q, px2_d;
  logic [7:0]        attr2_q, attr2_d;
  // Output stage
  logic [8:0]        pix_q, pix_d;
  logic              vout_q, vout_d;
  // Stage-local combinational terms
  logic              blank_s, hit_s, lit_s;
  logic [CHAR_W-1:0] glyph_sh_s;
  logic [8:0]        fg_s, bg_s;

  // Cell counters: frameStart beats lineEnd beats pixelValid.
  always_comb begin
    px_d    = px_q;
    col_d   = col_q;
    ric_d   = ric_q;
    crow_d  = crow_q;
    rbase_d = rbase_q;
    if (frameStart) begin
      px_d    = '0;
      col_d   = '0;
      ric_d   = '0;
      crow_d  = '0;
      rbase_d = '0;
    end else if (lineEnd) begin
      px_d  = '0;
      col_d = '0;
      if (ric_q == RIC_LAST) begin
        ric_d   = '0;
        crow_d  = (crow_q == CROW_MAX) ? CROW_MAX : crow_q + CROW_ONE;
        rbase_d = rbase_q + COLS_A;
      end else begin
        ric_d = ric_q + RIC_ONE;
      end
    end else if (pixelValid) begin
      if (px_q == PX_LAST) begin
        px_d  = '0;
        col_d = (col_q == COL_MAX) ? COL_MAX : col_q + COL_ONE;
      end else begin
        px_d = px_q + PX_ONE;
      end
    end else begin
      px_d = px_q;
    end
  end

  // Cursor blink: toggle phase every BLINK_FRAMES frame starts.
  always_comb begin
    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (frameStart) begin
      if (fcnt_q == BF_LAST) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + BF_ONE;
      end
    end else begin
      fcnt_d = fcnt_q;
    end
  end

  // Stage T: text address and per-pixel flags from the current counters.
  always_comb begin
    textAddr = TEXT_BASE + rbase_q + ADDR_W'(col_q);
    blank_s  = (col_q >= COL_MAX) || (crow_q >= CROW_MAX);
    hit_s    = cursorEn && (16'(col_q) == 16'(cursorCol)) &&
               (16'(crow_q) == 16'(cursorRow)) && (ric_q >= RIC_CUR);
  end

  // Stage T+1: glyph row address; idle cycles park it at the font base.
  always_comb begin
    if (v1_q) begin
      fontAddr = FONT_BASE + ADDR_W'(textData[7:0]) * CHAR_H_A + ADDR_W'(ric1_q);
    end else begin
      fontAddr = FONT_BASE;
    end
  end

  // Pipeline register inputs for the two fetch stages.
  always_comb begin
    v1_d     = pixelValid;
    px1_d    = px_q;
    ric1_d   = ric_q;
    blank1_d = blank_s;
    hit1_d   = hit_s;
    v2_d     = v1_q;
    px2_d    = px1_q;
    blank2_d = blank1_q;
    hit2_d   = hit1_q;
    attr2_d  = textData[15:8];
  end

  // Stage T+2: pick the glyph bit and resolve it to a colour.
  always_comb begin
    glyph_sh_s = fontData << px2_q;
    if (ATTR_EN) begin
      fg_s = attr_color(attr2_q[3:0]);
      bg_s = attr_color(attr2_q[7:4]);
    end else begin
      fg_s = FG_COLOR;
      bg_s = BG_COLOR;
    end
    lit_s = glyph_sh_s[CHAR_W-1] ^ (hit2_q & blink_q);
    if (!v2_q || blank2_q) begin
      pix_d = 9'h000;
    end else if (lit_s) begin
      pix_d = fg_s;
    end else begin
      pix_d = bg_s;
    end
    vout_d = v2_q;
  end

  // State register; synchronous reset drops every in-flight pixel.
  always_ff @(posedge vgaClock) begin
    if (reset) begin
      px_q     <= '0;
      col_q    <= '0;
      ric_q    <= '0;
      crow_q   <= '0;
      rbase_q  <= '0;
      fcnt_q   <= '0;
      blink_q  <= 1'b1;
      v1_q     <= 1'b0;
      px1_q    <= '0;
      ric1_q   <= '0;
      blank1_q <= 1'b0;
      hit1_q   <= 1'b0;
      v2_q     <= 1'b0;
      px2_q    <= '0;
      blank2_q <= 1'b0;
      hit2_q   <= 1'b0;
      attr2_q  <= 8'h00;
      pix_q    <= 9'h000;
      vout_q   <= 1'b0;
    end else begin
      px_q     <= px_d;
      col_q    <= col_d;
      ric_q    <= ric_d;
      crow_q   <= crow_d;
      rbase_q  <= rbase_d;
      fcnt_q   <= fcnt_d;
      blink_q  <= blink_d;
      v1_q     <= v1_d;
      px1_q    <= px1_d;
      ric1_q   <= ric1_d;
      blank1_q <= blank1_d;
      hit1_q   <= hit1_d;
      v2_q     <= v2_d;
      px2_q    <= px2_d;
      blank2_q <= blank2_d;
      hit2_q   <= hit2_d;
      attr2_q  <= attr2_d;
      pix_q    <= pix_d;
      vout_q   <= vout_d;
    end
  end

  assign pixelData     = pix_q;
  assign pixelOutValid = vout_q;

endmodule
